full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder.sv | 63 ++++++
 tb/tb_full_adder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// rtl/full_adder.sv - ripple-carry full adder with a combinational result and a registered, valid-qualified copy
// Optional build macro FULL_ADDER_OVF_EN adds the registered signed-overflow output ovf.

module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [WIDTH-1:0] q_sum,
   output logic             q_cout,
`ifdef FULL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             q_valid
);

   logic [WIDTH:0] c;

   // Explicit per-bit ripple so the WIDTH=1 build is a plain full-adder cell.
   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i]  = a[i] ^ b[i] ^ c[i];
         c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
   end

   assign cout = c[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_sum   <= '0;
         q_cout  <= 1'b0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= in_valid;
         if (in_valid) begin
            q_sum  <= sum;
            q_cout <= cout;
         end
      end
   end

`ifdef FULL_ADDER_OVF_EN
   // Two's-complement overflow: carry into the sign bit differs from carry out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= c[WIDTH] ^ c[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed-vector bench for full_adder at WIDTH=1 and WIDTH=4
// Build with FULL_ADDER_OVF_EN defined to include the ovf checks.

module tb_full_adder;

   logic       clk;
   logic       rst_n;
   logic       a1, b1, cin1, vld1;
   logic       sum1, cout1, qs1, qc1, qv1;
   logic [3:0] a4, b4;
   logic       cin4, vld4;
   logic [3:0] sum4, qs4;
   logic       cout4, qc4, qv4;
`ifdef FULL_ADDER_OVF_EN
   logic       ovf1, ovf4;
`endif

   int checks = 0;
   int errors = 0;

   full_adder #(.WIDTH(1)) u_fa1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(vld1),
      .sum(sum1), .cout(cout1), .q_sum(qs1), .q_cout(qc1),
`ifdef FULL_ADDER_OVF_EN
      .ovf(ovf1),
`endif
      .q_valid(qv1)
   );

   full_adder #(.WIDTH(4)) u_fa4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(vld4),
      .sum(sum4), .cout(cout4), .q_sum(qs4), .q_cout(qc4),
`ifdef FULL_ADDER_OVF_EN
      .ovf(ovf4),
`endif
      .q_valid(qv4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drive WIDTH=4 inputs at the falling edge, then sample just after the next rising edge
   task automatic step4(input logic [3:0] av, input logic [3:0] bv, input logic cv, input logic vv);
      @(negedge clk);
      a4 = av; b4 = bv; cin4 = cv; vld4 = vv;
      @(posedge clk);
      #1;
   endtask

   logic [1:0] tbl1 [8];

   initial begin
      // index = {a,b,cin}; entry = {cout,sum}
      tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      rst_n = 1'b0;
      a1 = 0; b1 = 0; cin1 = 0; vld1 = 0;
      a4 = 0; b4 = 0; cin4 = 0; vld4 = 0;
      #2;
      check("rst_q_sum", 32'(qs4), 32'h0);
      check("rst_q_cout", 32'(qc4), 32'h0);
      check("rst_q_valid", 32'(qv4), 32'h0);

      // combinational path works while held in reset
      for (int i = 0; i < 8; i++) begin
         a1 = i[2]; b1 = i[1]; cin1 = i[0];
         #1;
         check($sformatf("w1_comb_%0d", i), 32'({cout1, sum1}), 32'(tbl1[i]));
      end
      check("w1_q_in_reset", 32'({qc1, qs1, qv1}), 32'h0);

      a4 = 4'b1000; b4 = 4'b1101; cin4 = 1'b1; #1;
      check("w4_sub_sum", 32'(sum4), 32'h6);
      check("w4_sub_cout", 32'(cout4), 32'h1);
      a4 = 4'b0010; b4 = 4'b0111; cin4 = 1'b1; #1;
      check("w4_add_sum", 32'(sum4), 32'hA);
      check("w4_add_cout", 32'(cout4), 32'h0);
      a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1; #1;
      check("w4_max_sum", 32'(sum4), 32'hF);
      check("w4_max_cout", 32'(cout4), 32'h1);

      @(negedge clk);
      rst_n = 1'b1;

      // registered load, then hold with in_valid low
      step4(4'b1000, 4'b1000, 1'b0, 1'b1);
      check("reg_q_sum", 32'(qs4), 32'h0);
      check("reg_q_cout", 32'(qc4), 32'h1);
      check("reg_q_valid", 32'(qv4), 32'h1);
`ifdef FULL_ADDER_OVF_EN
      check("reg_ovf", 32'(ovf4), 32'h1);
`endif
      step4(4'b0011, 4'b0011, 1'b0, 1'b0);
      check("hold_q_valid", 32'(qv4), 32'h0);
      check("hold_q_sum", 32'(qs4), 32'h0);
      check("hold_q_cout", 32'(qc4), 32'h1);
`ifdef FULL_ADDER_OVF_EN
      check("hold_ovf", 32'(ovf4), 32'h1);
`endif

      step4(4'b0111, 4'b0001, 1'b0, 1'b1);
      check("ovf_a_q_sum", 32'(qs4), 32'h8);
      check("ovf_a_q_cout", 32'(qc4), 32'h0);
`ifdef FULL_ADDER_OVF_EN
      check("ovf_a_ovf", 32'(ovf4), 32'h1);
`endif
      step4(4'b1111, 4'b0001, 1'b0, 1'b1);
      check("ovf_b_q_sum", 32'(qs4), 32'h0);
      check("ovf_b_q_cout", 32'(qc4), 32'h1);
`ifdef FULL_ADDER_OVF_EN
      check("ovf_b_ovf", 32'(ovf4), 32'h0);
`endif

      // asynchronous reset between edges while q_valid is high
      step4(4'b0101, 4'b0100, 1'b0, 1'b1);
      check("pre_rst_q_sum", 32'(qs4), 32'h9);
      check("pre_rst_q_valid", 32'(qv4), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_q_sum", 32'(qs4), 32'h0);
      check("async_q_cout", 32'(qc4), 32'h0);
      check("async_q_valid", 32'(qv4), 32'h0);
`ifdef FULL_ADDER_OVF_EN
      check("async_ovf", 32'(ovf4), 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step4(4'b0001, 4'b0111, 1'b0, 1'b1);
      check("post_rst_q_sum", 32'(qs4), 32'h8);
      check("post_rst_q_cout", 32'(qc4), 32'h0);
      check("post_rst_q_valid", 32'(qv4), 32'h1);

      // WIDTH=1 registered path
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; vld1 = 1'b1;
      @(posedge clk);
      #1;
      check("w1_reg", 32'({qc1, qs1, qv1}), 32'b111);
`ifdef FULL_ADDER_OVF_EN
      check("w1_ovf", 32'(ovf1), 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
